rr_req_arbiter: RTL and testbench

Round-robin request/grant arbiter that shares one req/gnt-style resource among N requesters. Each requester raises `req[i]` and holds it while it needs the resource. The arbiter issues a registered, one-hot `gnt`, which a requester keeps until it drops `req` or until a hold-time limit forces release. The block sits between the stimulus/requester agents and the single-port resource, and is driven and sampled on `posedge clk` like the rest of the req/gnt logic.

---
 rtl/rr_req_arbiter.sv | 154 +++++++++++++++
 tb/tb_rr_req_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rr_req_arbiter.sv
// rr_req_arbiter
// Round-robin arbiter sharing one req/gnt resource among N requesters.
// A grant is registered and one-hot. It is held until the owner drops its
// request or until MAX_HOLD consecutive cycles have elapsed. At least one idle
// cycle separates any two grants.
//
// Ports:
//   clk      - clock, all state updates on the rising edge
//   rstn     - asynchronous active-low reset
//   en       - allows new grants; sampled only while idle
//   req      - level-sensitive request vector [N-1:0]
//   gnt      - registered one-hot grant, all zeros when idle
//   gnt_id   - index of the current owner, 0 when not busy
//   busy     - high while any gnt bit is high
//   timeout  - one-cycle pulse after a grant is force-released
module rr_req_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = $clog2(N),
    parameter int CW       = $clog2(MAX_HOLD + 1)
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           en,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [CW-1:0]  HOLD_MAX = CW'(MAX_HOLD);
    localparam logic [IDW-1:0] LAST_RST = IDW'(N - 1);

    state_t         state_r, state_s;
    logic [N-1:0]   gnt_r, gnt_s;
    logic [IDW-1:0] gnt_id_r, gnt_id_s;
    logic           busy_r, busy_s;
    logic           timeout_r, timeout_s;
    logic [IDW-1:0] last_r, last_s;
    logic [CW-1:0]  cnt_r, cnt_s;

    logic           found_s;
    logic [IDW-1:0] winner_s;
    int             idx_s;
    logic           owner_req_s;

    // Round-robin search: first requester at or after last+1, wrapping modulo N.
    always_comb begin
        found_s  = 1'b0;
        winner_s = {IDW{1'b0}};
        idx_s    = 32'sd0;
        for (int i = 0; i < N; i++) begin
            idx_s = (int'(last_r) + 32'sd1 + i) % N;
            if (!found_s && req[idx_s[IDW-1:0]]) begin
                found_s  = 1'b1;
                winner_s = idx_s[IDW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Request level of the current owner.
    always_comb begin
        owner_req_s = req[gnt_id_r];
    end

    // Next-state and next-output logic; a release always clears the grant
    // registers, and only a limit-driven release raises timeout.
    always_comb begin
        state_s   = state_r;
        gnt_s     = gnt_r;
        gnt_id_s  = gnt_id_r;
        busy_s    = busy_r;
        timeout_s = 1'b0;
        last_s    = last_r;
        cnt_s     = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (en && found_s) begin
                    state_s          = ST_GRANT;
                    gnt_s            = {N{1'b0}};
                    gnt_s[winner_s]  = 1'b1;
                    gnt_id_s         = winner_s;
                    busy_s           = 1'b1;
                    last_s           = winner_s;
                    cnt_s            = CW'(1'b1);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!owner_req_s) begin
                    // Owner let go: normal release, even when the limit is reached.
                    state_s  = ST_IDLE;
                    gnt_s    = {N{1'b0}};
                    gnt_id_s = {IDW{1'b0}};
                    busy_s   = 1'b0;
                    cnt_s    = {CW{1'b0}};
                end else if (cnt_r >= HOLD_MAX) begin
                    state_s   = ST_IDLE;
                    gnt_s     = {N{1'b0}};
                    gnt_id_s  = {IDW{1'b0}};
                    busy_s    = 1'b0;
                    cnt_s     = {CW{1'b0}};
                    timeout_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CW'(1'b1);
                end
            end
            default: begin
                state_s  = ST_IDLE;
                gnt_s    = {N{1'b0}};
                gnt_id_s = {IDW{1'b0}};
                busy_s   = 1'b0;
                cnt_s    = {CW{1'b0}};
                last_s   = LAST_RST;
            end
        endcase
    end

    // State and output registers; last resets to N-1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            gnt_r     <= {N{1'b0}};
            gnt_id_r  <= {IDW{1'b0}};
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
            last_r    <= LAST_RST;
            cnt_r     <= {CW{1'b0}};
        end else begin
            state_r   <= state_s;
            gnt_r     <= gnt_s;
            gnt_id_r  <= gnt_id_s;
            busy_r    <= busy_s;
            timeout_r <= timeout_s;
            last_r    <= last_s;
            cnt_r     <= cnt_s;
        end
    end

    assign gnt     = gnt_r;
    assign gnt_id  = gnt_id_r;
    assign busy    = busy_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_rr_req_arbiter.sv
// tb_rr_req_arbiter
// Bench for rr_req_arbiter with N=4, MAX_HOLD=8. Each step drives en/req just
// after a rising edge, queues the outputs expected after the next edge, then
// pops and compares them one time unit after that edge. Also checks the
// one-hot, busy and timeout invariants every step.
module tb_rr_req_arbiter;

    logic       clk;
    logic       rstn;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int checks;
    int errors;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       to;
    } exp_t;

    typedef struct {
        logic       en;
        logic [3:0] req;
        exp_t       e;
    } vec_t;

    exp_t  sb[$];
    string nq[$];
    vec_t  tbl[$];

    rr_req_arbiter #(.N(4), .MAX_HOLD(8)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic e, input logic [3:0] r, input logic [3:0] g,
                                input logic [1:0] id, input logic b, input logic t);
        vec_t v;
        v.en     = e;
        v.req    = r;
        v.e.gnt  = g;
        v.e.id   = id;
        v.e.busy = b;
        v.e.to   = t;
        return v;
    endfunction

    task automatic check_outputs(input string nm, input exp_t x);
        checks++;
        if (gnt !== x.gnt || gnt_id !== x.id || busy !== x.busy || timeout !== x.to) begin
            errors++;
            $display("FAIL %s t=%0t got gnt=%b id=%0d busy=%b to=%b want gnt=%b id=%0d busy=%b to=%b",
                     nm, $time, gnt, gnt_id, busy, timeout, x.gnt, x.id, x.busy, x.to);
        end
        checks++;
        if (!$onehot0(gnt)) begin
            errors++;
            $display("FAIL onehot0 %s got gnt=%b want at most one bit", nm, gnt);
        end
        checks++;
        if (busy !== (|gnt)) begin
            errors++;
            $display("FAIL busy_or %s got busy=%b want %b", nm, busy, |gnt);
        end
        checks++;
        if (timeout === 1'b1 && gnt !== 4'b0000) begin
            errors++;
            $display("FAIL timeout_idle %s got gnt=%b want 0000", nm, gnt);
        end
    endtask

    // One cycle: drive inputs, queue expectation, compare after the edge.
    task automatic tick(input logic e, input logic [3:0] r, input logic [3:0] g,
                        input logic [1:0] id, input logic b, input logic t, input string nm);
        exp_t  x;
        string n2;
        en  = e;
        req = r;
        x.gnt  = g;
        x.id   = id;
        x.busy = b;
        x.to   = t;
        sb.push_back(x);
        nq.push_back(nm);
        @(posedge clk);
        #1;
        x  = sb.pop_front();
        n2 = nq.pop_front();
        check_outputs(n2, x);
    endtask

    // Assert reset between edges, confirm outputs clear at once, release after two edges.
    task automatic do_reset(input string nm);
        exp_t z;
        z = '{gnt: 4'b0000, id: 2'd0, busy: 1'b0, to: 1'b0};
        rstn = 1'b0;
        #2;
        check_outputs(nm, z);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn   = 1'b0;
        en     = 1'b0;
        req    = 4'b0000;

        // Reset state, then all four requesting: 0,1,2,3,0 each for 8 cycles
        // followed by a forced-release idle cycle with timeout.
        #1;
        do_reset("reset_state");
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 8; c++) begin
                tick(1'b1, 4'b1111, 4'b0001 << (g % 4), 2'(g % 4), 1'b1, 1'b0, "rr_all_hold");
            end
            tick(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b1, "rr_all_timeout");
        end
        tick(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_all_clear");

        // Table section starts from a fresh reset (last = 3).
        do_reset("reset_again");
        // Normal release of requester 2 after three cycles.
        tbl.push_back(mk(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        // Fairness: set last=1, then 1001 alternates 3,0,3.
        tbl.push_back(mk(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        // Enable gating: no grant while en=0, grant continues when en drops mid-grant.
        tbl.push_back(mk(1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0));
        foreach (tbl[i]) begin
            tick(tbl[i].en, tbl[i].req, tbl[i].e.gnt, tbl[i].e.id, tbl[i].e.busy, tbl[i].e.to,
                 $sformatf("table_row_%0d", i));
        end

        // Boundary: owner drops req at the edge where cnt == MAX_HOLD -> no timeout.
        for (int c = 0; c < 8; c++) begin
            tick(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "bound_hold");
        end
        tick(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "bound_normal_release");
        // Holding one more edge forces release; lone requester is re-granted after the gap.
        for (int c = 0; c < 8; c++) begin
            tick(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "bound_hold2");
        end
        tick(1'b1, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b1, "bound_forced_release");
        tick(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "bound_regrant");
        tick(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "bound_clear");

        // Reset mid-grant while requester 3 owns; afterwards 1001 grants 0 first.
        tick(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, "mid_grant_setup");
        tick(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, "mid_grant_hold");
        do_reset("reset_mid_grant");
        tick(1'b1, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0, "post_reset_first");
        tick(1'b1, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0, "post_reset_release");
        tick(1'b1, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, "post_reset_next");
        tick(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "post_reset_clear");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
